// File: rtl/wdom_rptr_sync_pkg.sv
// Shared async-FIFO definitions: default geometry, Gray/binary conversion and
// the almost_full watermark state encoding.
package wdom_rptr_sync_pkg;

  localparam int ADDR_WIDTH_DEF = 3;

  typedef enum logic {
    AF_LOW  = 1'b0,
    AF_HIGH = 1'b1
  } af_state_t;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Works for any pointer width up to 32: callers zero-extend, so the extra
  // high bits contribute nothing to the prefix XOR.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/wdom_rptr_sync_if.sv
// Signal bundle for the write-domain read-pointer receiver. The master side
// drives pointers and controls; the slave side (the receiver) returns status.
interface wdom_rptr_sync_if
  import wdom_rptr_sync_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] rptr_gray;
  logic [PTR_W-1:0] wptr_gray;
  logic [PTR_W-1:0] afull_thresh;
  logic             err_clr;

  logic [PTR_W-1:0] rptr_sync;
  logic [PTR_W-1:0] wlevel;
  logic [PTR_W-1:0] wfree;
  logic             almost_full;
  logic             sync_err;
  af_state_t        af_state;

  modport master (
    output rptr_gray, wptr_gray, afull_thresh, err_clr,
    input  rptr_sync, wlevel, wfree, almost_full, sync_err, af_state
  );

  modport slave (
    input  rptr_gray, wptr_gray, afull_thresh, err_clr,
    output rptr_sync, wlevel, wfree, almost_full, sync_err, af_state
  );

endinterface

// File: rtl/wdom_rptr_sync_cdc_sync_bus.sv
// Multi-bit flop-chain synchronizer for Gray-coded pointers. No logic between
// stages; the input must change at most one bit per source-clock step.
module cdc_sync_bus #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/wdom_rptr_sync.sv
// Write-domain end of the read-pointer crossing: synchronizes the Gray read
// pointer and derives occupancy, free space, almost_full and an integrity flag.
module wdom_rptr_sync
  import wdom_rptr_sync_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int AF_HYST     = 1
) (
  input logic              wclk,
  input logic              rst_n,
  wdom_rptr_sync_if.slave  bus
);

  localparam int               PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] DEPTH = PTR_W'(depth_of(ADDR_WIDTH));
  localparam logic [PTR_W-1:0] HYST  = PTR_W'(AF_HYST);

  logic [PTR_W-1:0] rptr_sync;
  logic [PTR_W-1:0] rptr_sync_q;
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] diff;
  logic [PTR_W-1:0] level_next;
  logic [PTR_W-1:0] wlevel_q;
  logic [PTR_W-1:0] wfree_q;
  logic [PTR_W-1:0] af_lo;
  logic             gray_step_err;
  logic             level_err;
  logic             sync_err_q;
  af_state_t        af_state;
  af_state_t        af_state_next;

  cdc_sync_bus #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (wclk),
    .rst_n (rst_n),
    .d     (bus.rptr_gray),
    .q     (rptr_sync)
  );

  assign rbin = PTR_W'(gray2bin(32'(rptr_sync)));
  assign wbin = PTR_W'(gray2bin(32'(bus.wptr_gray)));

  // Modulo subtract absorbs pointer wrap; anything above DEPTH is impossible.
  assign diff       = wbin - rbin;
  assign level_err  = (diff > DEPTH);
  assign level_next = level_err ? DEPTH : diff;

  // A legal Gray crossing moves at most one bit between consecutive samples.
  assign gray_step_err = ($countones(rptr_sync ^ rptr_sync_q) > 1);

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_sync_q <= '0;
      wlevel_q    <= '0;
      wfree_q     <= DEPTH;
      sync_err_q  <= 1'b0;
    end else begin
      rptr_sync_q <= rptr_sync;
      wlevel_q    <= level_next;
      wfree_q     <= DEPTH - level_next;
      if (gray_step_err || level_err) begin
        sync_err_q <= 1'b1;
      end else if (bus.err_clr) begin
        sync_err_q <= 1'b0;
      end
    end
  end

  // Release level saturates at 0, so a small threshold keeps the flag latched.
  assign af_lo = (bus.afull_thresh > HYST) ? (bus.afull_thresh - HYST) : '0;

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      af_state <= AF_LOW;
    end else begin
      af_state <= af_state_next;
    end
  end

  always_comb begin
    af_state_next = af_state;
    case (af_state)
      AF_LOW:  if (wlevel_q >= bus.afull_thresh) af_state_next = AF_HIGH;
      AF_HIGH: if (wlevel_q < af_lo)             af_state_next = AF_LOW;
      default: af_state_next = AF_LOW;
    endcase
  end

  assign bus.rptr_sync   = rptr_sync;
  assign bus.wlevel      = wlevel_q;
  assign bus.wfree       = wfree_q;
  assign bus.almost_full = (af_state == AF_HIGH);
  assign bus.sync_err    = sync_err_q;
  assign bus.af_state    = af_state;

endmodule
